// File: rtl/proc_pkg.sv
// Shared proc-stage definitions: default register-bank geometry and the
// output-stage state encoding used by reg_bank_out.
package proc_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int SEL_BITS_DEF = 3;

    // One-entry output holding stage: empty or holding a completed result.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mux_tree.sv
// Binary mux tree: selects one of 2^switch_bits data_width-wide sources.
// Level l halves the candidate set using select bit l (LSB first).
module mux_tree #(
    parameter int switch_bits = 3,
    parameter int data_width  = 8
) (
    input  logic [switch_bits-1:0]                          sel,
    input  logic [(1<<switch_bits)-1:0][data_width-1:0]     din,
    output logic [data_width-1:0]                           dout
);

    localparam int N = 1 << switch_bits;

    // Reduce pairs in place, one level per select bit, until one source remains.
    always_comb begin
        logic [N-1:0][data_width-1:0] v;
        v = din;
        for (int l = 0; l < switch_bits; l++) begin
            for (int i = 0; i < N / 2; i++) begin
                if (i < (N >> (l + 1))) begin
                    v[i] = sel[l] ? v[2*i+1] : v[2*i];
                end
            end
        end
        dout = v[0];
    end

endmodule

// File: rtl/reg_bank_out.sv
// One-entry registered output stage with valid/ready handshake.
// in_ready depends only on the held state and out_ready, never on in_valid,
// so upstream may compute its request from in_ready without a loop.
module reg_bank_out
    import proc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept;

    // Next state and data: load on accept, drain on out_ready, hold otherwise.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        in_ready = (state_q == EMPTY) | out_ready;
        accept   = in_valid & in_ready;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept)         state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        // out_data keeps its last value when draining to EMPTY
        if (accept) data_d = in_data;
    end

    // State and data registers; reset discards any pending result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/reg_bank.sv
// Register bank: one write port, one handshaked read port through a mux tree
// and a one-entry registered output stage (1-cycle read latency).
// Optional macro REG_BANK_BYPASS_EN forwards same-cycle write data (and
// same-cycle clear) into the read result; without it reads see pre-write,
// pre-clear contents.
module reg_bank
    import proc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SEL_BITS = SEL_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [SEL_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_valid,
    input  logic [SEL_BITS-1:0] rd_addr,
    output logic                rd_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready
);

    localparam int N = 1 << SEL_BITS;

    logic [N-1:0][DATA_W-1:0] entry_q, entry_d;
    logic [DATA_W-1:0]        rd_mux;
    logic [DATA_W-1:0]        rd_data;

    // Entry update: clear beats write; entry 0 is ordinary storage.
    always_comb begin
        entry_d = entry_q;
        if (clr)        entry_d = '0;
        else if (wr_en) entry_d[wr_addr] = wr_data;
    end

    // Entry storage, zeroed asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) entry_q <= '0;
        else      entry_q <= entry_d;
    end

    mux_tree #(
        .switch_bits (SEL_BITS),
        .data_width  (DATA_W)
    ) u_mux (
        .sel  (rd_addr),
        .din  (entry_q),
        .dout (rd_mux)
    );

`ifdef REG_BANK_BYPASS_EN
    // Forward the same-cycle clear or matching write into the read result.
    always_comb begin
        rd_data = rd_mux;
        if (clr)                               rd_data = '0;
        else if (wr_en && wr_addr == rd_addr)  rd_data = wr_data;
    end
`else
    // Reads observe stored contents only (pre-write / pre-clear values).
    always_comb begin
        rd_data = rd_mux;
    end
`endif

    reg_bank_out #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid),
        .in_data   (rd_data),
        .in_ready  (rd_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus pushes expected read results into a
// queue, a negedge monitor compares whatever the DUT presents.
module tb_reg_bank;

    localparam int DW = 8;
    localparam int SB = 3;
    localparam int N  = 1 << SB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [SB-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid = 1'b0;
    logic [SB-1:0] rd_addr = '0;
    logic          out_ready = 1'b0;
    logic          rd_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference: storage array plus a queue of results owed to the consumer.
    // The output stage holds at most one result, so a read is accepted exactly
    // when nothing is owed once this cycle's consumption is accounted for.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] q [$];

    reg_bank #(.DATA_W(DW), .SEL_BITS(SB)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] exp_read();
`ifdef REG_BANK_BYPASS_EN
        if (clr) return '0;
        if (wr_en && wr_addr == rd_addr) return wr_data;
`endif
        return mem[rd_addr];
    endfunction

    // Reference update at a clock edge, using the inputs the DUT samples.
    task automatic model_edge();
        if (rd_valid && q.size() == 0) q.push_back(exp_read());
        if (clr) begin
            for (int i = 0; i < N; i++) mem[i] = '0;
        end else if (wr_en) begin
            mem[wr_addr] = wr_data;
        end
    endtask

    task automatic step(input logic we, input int wa, input int wd, input logic rv,
                        input int ra, input logic ordy, input logic cl);
        wr_en     = we;
        wr_addr   = wa[SB-1:0];
        wr_data   = wd[DW-1:0];
        rd_valid  = rv;
        rd_addr   = ra[SB-1:0];
        out_ready = ordy;
        clr       = cl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: compare handshake and presented data, retire owed results.
    always @(negedge clk) begin
        if (rst) begin
            chk("rd_ready", {31'b0, rd_ready}, {31'b0, (q.size() == 0) || out_ready});
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            if (out_valid && q.size() != 0) chk("out_data", {24'b0, out_data}, {24'b0, q[0]});
            if (q.size() != 0 && out_ready) void'(q.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < N; i++) mem[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_rd_ready", {31'b0, rd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back reads after writes
        step(1, 3, 'hA5, 0, 0, 1, 0);
        step(1, 5, 'h3C, 0, 0, 1, 0);
        step(0, 0, 0, 1, 3, 1, 0);
        step(0, 0, 0, 1, 5, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Stall: request held while consumer is not ready
        step(0, 0, 0, 1, 3, 0, 0);
        repeat (4) step(0, 0, 0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 5, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Same-cycle write and read of one address
        step(1, 2, 'h77, 0, 0, 1, 0);
        step(1, 2, 'h11, 1, 2, 1, 0);
        step(0, 0, 0, 1, 2, 1, 0);

        // Clear beats a same-cycle write; read everything back
        step(1, 1, 'hFF, 0, 0, 1, 1);
        for (int i = 0; i < N; i++) step(0, 0, 0, 1, i, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Reset while holding a stalled result
        step(1, 6, 'h5A, 0, 0, 1, 0);
        step(0, 0, 0, 1, 6, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_out_data", {24'b0, out_data}, 32'd0);
        q.delete();
        for (int i = 0; i < N; i++) mem[i] = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 1, 6, 1, 0);
        step(0, 0, 0, 1, 3, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            step($urandom_range(0, 1), $urandom_range(0, N-1), $urandom_range(0, 255),
                 $urandom_range(0, 9) < 6, $urandom_range(0, N-1),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
        end

        // Drain: every accepted read must have been delivered exactly once
        repeat (3) step(0, 0, 0, 0, 0, 1, 0);
        chk("drain_owed", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parameterised register bank with one write port and one handshaked read port.
- Read selection is the mux-tree stage (2^SEL_BITS sources, DATA_W wide); this block owns the entry storage feeding that tree and a one-entry registered output stage after it.
- Sits between the proc write-back path and the operand consumer.
- Consumer may stall reads via out_ready.

Parameters:
- DATA_W, 8, width of each entry and of read/write data.
- SEL_BITS, 3, address width; number of entries N = 2^SEL_BITS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of all entries.
- wr_en  in  1  write strobe.
- wr_addr  in  SEL_BITS  write entry index.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request valid.
- rd_addr  in  SEL_BITS  read entry index.
- rd_ready  out  1  read request accepted this cycle when high with rd_valid.
- out_valid  out  1  out_data holds a completed read.
- out_data  out  DATA_W  read result.
- out_ready  in  1  consumer takes out_data when high with out_valid.

Behaviour:
- Reset (rst low, asynchronous):
  - all N entries = 0.
  - out_valid = 0, out_data = 0, rd_ready = 1.
  - Release is synchronous to clk.
- Write:
  - wr_en high at a clk edge sets entry[wr_addr] = wr_data.
  - Visible to reads issued the following cycle or later.
  - Entry 0 is ordinary storage, not hardwired.
- Clear:
  - clr high at a clk edge zeroes all entries.
  - clr and wr_en in the same cycle: clr wins, the write is dropped.
  - clr does not affect out_valid or out_data.
- Read handshake:
  - rd_ready = !out_valid | out_ready. This is combinational from out_valid and out_ready; there is no path from rd_valid to rd_ready.
  - Accept = rd_valid & rd_ready.
  - On accept: out_data <= entry[rd_addr], out_valid <= 1. Latency is 1 cycle from accept to out_valid.
- Output stage state machine:
  - EMPTY (out_valid = 0):
    - accept -> FULL.
    - otherwise stay in EMPTY.
  - FULL (out_valid = 1):
    - out_ready & accept -> FULL, new data loaded. Back-to-back reads give 1 result per cycle.
    - out_ready & !accept -> EMPTY; out_data keeps its last value.
    - !out_ready -> FULL; out_data held stable and rd_ready = 0.
- Same-cycle write and read, same address: read returns the pre-write value (without the optional feature).
- Same-cycle clr and read: read returns the pre-clear value.
- rd_addr and wr_addr cover all N entries; no out-of-range case exists.
- Reset asserted mid-operation: the pending output is discarded (out_valid = 0) and entries are zeroed immediately.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined:
  - accept with wr_en & (wr_addr == rd_addr) & !clr in the same cycle returns wr_data (write-through forward).
  - accept with clr asserted returns 0.
- Undefined: pre-write and pre-clear values are returned as specified above.
- Adds one comparator and one DATA_W 2:1 select in front of the output register; latency unchanged.

Decomposition:
- Shared package proc_pkg holds:
  - default DATA_W and SEL_BITS constants.
  - output-stage state encoding (EMPTY = 1'b0, FULL = 1'b1).
- Read selection instantiates the existing mux-tree module with switch_bits = SEL_BITS and data_width = DATA_W; it is not reimplemented.
- One natural sub-module: reg_bank_out, the output holding register with the valid/ready logic and state machine. It is reusable by other proc stages.

Test Plan:
1. Reset, then write entry3=0xA5 and entry5=0x3C. Read 3 then 5 back-to-back with out_ready=1 -> out_data 0xA5 at cycle+1, 0x3C at cycle+2, out_valid high both cycles.
2. Hold out_ready=0 after a read of entry3 with rd_valid held high -> rd_ready=0, out_data stays 0xA5 for 4 cycles. Raise out_ready -> next read is accepted that cycle.
3. wr_en with addr2=0x11 and read of addr2 in the same cycle (entry2 previously 0x77) -> out_data 0x77 without the macro, 0x11 with REG_BANK_BYPASS_EN. The following read returns 0x11.
4. clr and wr_en (addr1=0xFF) in the same cycle, then read entries 0..7 -> all 0x00.
5. Assert rst low while out_valid=1 with out_ready=0 -> out_valid=0 and out_data=0 immediately. After release, a read of any entry returns 0x00.
6. Random write/read/stall traffic over 10k cycles, checked against a scoreboard model, for both macro settings -> no mismatch, no dropped or duplicated results.
